// File: rtl/pc_next_ctrl_if.sv
// Next-PC control bundle: PC-register feedback, branch resolution and flags in, next PC and status out.
// Purely wires; master drives the pipeline side, slave is the next-PC control stage.
interface pc_next_ctrl_if;
  logic [15:0] pc_cur;
  logic        stall;
  logic        halt_dec;
  logic        br_valid;
  logic [2:0]  br_cond;
  logic [8:0]  br_imm;
  logic        br_reg_valid;
  logic [15:0] br_reg_target;
  logic [2:0]  flags;
  logic [15:0] pc_next;
  logic [15:0] pc_plus2;
  logic        flush;
  logic        pend_valid;
  logic        halted;

  modport master (
    output pc_cur, stall, halt_dec, br_valid, br_cond, br_imm,
           br_reg_valid, br_reg_target, flags,
    input  pc_next, pc_plus2, flush, pend_valid, halted
  );

  modport slave (
    input  pc_cur, stall, halt_dec, br_valid, br_cond, br_imm,
           br_reg_valid, br_reg_target, flags,
    output pc_next, pc_plus2, flush, pend_valid, halted
  );
endinterface

// File: rtl/pc_next_ctrl.sv
// Next-PC selection for a write-enable-less PC register: hold, PC+2, B/BR redirect, HALT.
// Latency: pc_next/pc_plus2/flush combinational; stall holds PC and parks one redirect for the first unstalled cycle.
module pc_next_ctrl (
  input logic           clk,
  input logic           rst,
  pc_next_ctrl_if.slave bus
);
  typedef enum logic {RUN, HALT} state_t;

  state_t      state;
  logic [15:0] pend_target;
  logic        pend_valid_q;
  logic        halted_q;

  logic        n_f, z_f, v_f;
  logic        cond_true;
  logic        taken;
  logic [15:0] pc_plus2;
  logic [15:0] b_target;
  logic [15:0] target;
  logic [15:0] pc_next_c;
  logic        flush_c;

  assign {n_f, z_f, v_f} = bus.flags;
  assign pc_plus2 = bus.pc_cur + 16'd2;
  // Immediate is a signed word offset: sign-extend and scale to bytes.
  assign b_target = pc_plus2 + {{6{bus.br_imm[8]}}, bus.br_imm, 1'b0};
  assign target   = bus.br_reg_valid ? bus.br_reg_target : b_target;

  always_comb begin
    cond_true = 1'b1;
    case (bus.br_cond)
      3'b000:  cond_true = ~z_f;
      3'b001:  cond_true = z_f;
      3'b010:  cond_true = ~z_f & ~n_f;
      3'b011:  cond_true = n_f;
      3'b100:  cond_true = z_f | ~n_f;
      3'b101:  cond_true = n_f | z_f;
      3'b110:  cond_true = v_f;
      default: cond_true = 1'b1;
    endcase
  end

  assign taken = (bus.br_valid & cond_true) | bus.br_reg_valid;

  always_comb begin
    pc_next_c = bus.pc_cur;
    flush_c   = 1'b0;
    if (rst) begin
      pc_next_c = 16'h0000;
    end else if (state == RUN && !bus.stall) begin
      // A parked redirect beats everything in this cycle; halt/branch inputs are wrong-path.
      if (pend_valid_q) begin
        pc_next_c = pend_target;
        flush_c   = 1'b1;
      end else if (!bus.halt_dec) begin
        if (taken) begin
          pc_next_c = target;
          flush_c   = 1'b1;
        end else begin
          pc_next_c = pc_plus2;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      pend_valid_q <= 1'b0;
      pend_target  <= 16'h0000;
      halted_q     <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bus.stall) begin
            if (taken && !pend_valid_q) begin
              pend_valid_q <= 1'b1;
              pend_target  <= target;
            end
          end else if (pend_valid_q) begin
            pend_valid_q <= 1'b0;
          end else if (bus.halt_dec) begin
            state    <= HALT;
            halted_q <= 1'b1;
          end
        end
        default: begin
          pend_valid_q <= 1'b0;
          halted_q     <= 1'b1;
        end
      endcase
    end
  end

  assign bus.pc_next    = pc_next_c;
  assign bus.pc_plus2   = pc_plus2;
  assign bus.flush      = flush_c;
  assign bus.pend_valid = pend_valid_q;
  assign bus.halted     = halted_q;
endmodule

// File: tb/tb_pc_next_ctrl.sv
// Bench for pc_next_ctrl: directed scenarios plus randomized cycles against an arithmetic reference model.
// The bench plays the PC register in free-run scenarios by feeding pc_next back into pc_cur.
module tb_pc_next_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pc_next_ctrl_if bus ();

  pc_next_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  bit      m_halt;
  int      m_pend[$];

  function automatic bit m_cond();
    bit n, z, v;
    n = bus.flags[2];
    z = bus.flags[1];
    v = bus.flags[0];
    case (int'(bus.br_cond))
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || !n;
      5: return n || z;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit m_taken();
    return bus.br_reg_valid || (bus.br_valid && m_cond());
  endfunction

  function automatic int m_target();
    int imm_s;
    if (bus.br_reg_valid) return int'(bus.br_reg_target);
    imm_s = int'(bus.br_imm);
    if (imm_s >= 256) imm_s = imm_s - 512;
    return (int'(bus.pc_cur) + 2 + 2 * imm_s) & 32'hFFFF;
  endfunction

  // Expected {flush, pc_next} for the current inputs and model state.
  function automatic logic [16:0] m_out();
    int pc;
    pc = int'(bus.pc_cur);
    if (rst)                    return 17'h0;
    if (m_halt || bus.stall)    return {1'b0, 16'(pc)};
    if (m_pend.size() != 0)     return {1'b1, 16'(m_pend[0])};
    if (bus.halt_dec)           return {1'b0, 16'(pc)};
    if (m_taken())              return {1'b1, 16'(m_target())};
    return {1'b0, 16'((pc + 2) & 32'hFFFF)};
  endfunction

  task automatic m_edge();
    if (rst) begin
      m_halt = 1'b0;
      m_pend.delete();
    end else if (!m_halt) begin
      if (bus.stall) begin
        if (m_taken() && m_pend.size() == 0) m_pend.push_back(m_target());
      end else if (m_pend.size() != 0) begin
        void'(m_pend.pop_front());
      end else if (bus.halt_dec) begin
        m_halt = 1'b1;
      end
    end
  endtask

  task automatic tick();
    m_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall = 0; bus.halt_dec = 0; bus.br_valid = 0; bus.br_cond = 0;
    bus.br_imm = 0; bus.br_reg_valid = 0; bus.br_reg_target = 0; bus.flags = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.pc_cur = 16'h1234;
    rst = 1;
    #1;
    checks++;
    if (bus.pc_next !== 16'h0000) begin
      errors++; $display("FAIL reset_pc_next: got %h want 0000", bus.pc_next);
    end
    checks++;
    if (bus.flush !== 1'b0) begin
      errors++; $display("FAIL reset_flush: got %b want 0", bus.flush);
    end
    tick();
    rst = 0;
    bus.pc_cur = 16'h0000;
    #1;
    checks++;
    if ({bus.pend_valid, bus.halted} !== 2'b00) begin
      errors++; $display("FAIL reset_state: pend/halted got %b want 00", {bus.pend_valid, bus.halted});
    end
  endtask

  task automatic test_free_run();
    logic [15:0] nxt;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.pc_cur !== 16'(2 * i) || bus.flush !== 1'b0) begin
        errors++; $display("FAIL free_run[%0d]: pc %h flush %b want %h 0", i, bus.pc_cur, bus.flush, 16'(2 * i));
      end
      nxt = bus.pc_next;
      tick();
      bus.pc_cur = nxt;
      #1;
    end
  endtask

  task automatic test_branch();
    bus.pc_cur = 16'h0010; bus.br_valid = 1; bus.br_cond = 3'b001;
    bus.br_imm = 9'h1FC; bus.flags = 3'b010;
    #1;
    checks++;
    if ({bus.flush, bus.pc_next} !== {1'b1, 16'h000A}) begin
      errors++; $display("FAIL branch_taken: flush %b pc %h want 1 000a", bus.flush, bus.pc_next);
    end
    bus.flags = 3'b000;
    #1;
    checks++;
    if ({bus.flush, bus.pc_next} !== {1'b0, 16'h0012}) begin
      errors++; $display("FAIL branch_not_taken: flush %b pc %h want 0 0012", bus.flush, bus.pc_next);
    end
    bus.br_reg_valid = 1; bus.br_reg_target = 16'hBEEF;
    #1;
    checks++;
    if ({bus.flush, bus.pc_next} !== {1'b1, 16'hBEEF}) begin
      errors++; $display("FAIL br_reg_priority: flush %b pc %h want 1 beef", bus.flush, bus.pc_next);
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    bus.pc_cur = 16'hFFFE;
    #1;
    checks++;
    if (bus.pc_plus2 !== 16'h0000) begin
      errors++; $display("FAIL wrap_plus2: got %h want 0000", bus.pc_plus2);
    end
    bus.pc_cur = 16'hFFF0; bus.br_valid = 1; bus.br_cond = 3'b111; bus.br_imm = 9'h0FF;
    #1;
    checks++;
    if (bus.pc_next !== 16'h01F0) begin
      errors++; $display("FAIL wrap_target: got %h want 01f0", bus.pc_next);
    end
    idle_inputs();
  endtask

  task automatic test_pending();
    bus.pc_cur = 16'h0100; bus.stall = 1;
    bus.br_reg_valid = 1; bus.br_reg_target = 16'h1234;
    #1;
    checks++;
    if ({bus.flush, bus.pc_next} !== {1'b0, 16'h0100}) begin
      errors++; $display("FAIL pend_hold: flush %b pc %h want 0 0100", bus.flush, bus.pc_next);
    end
    tick();
    bus.br_reg_target = 16'h5678;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({bus.pend_valid, bus.flush, bus.pc_next} !== {2'b10, 16'h0100}) begin
        errors++; $display("FAIL pend_stall[%0d]: pend %b flush %b pc %h want 1 0 0100", i, bus.pend_valid, bus.flush, bus.pc_next);
      end
      tick();
    end
    bus.stall = 0; bus.br_reg_valid = 0;
    bus.br_valid = 1; bus.br_cond = 3'b111; bus.halt_dec = 1;
    #1;
    checks++;
    if ({bus.flush, bus.pc_next} !== {1'b1, 16'h1234}) begin
      errors++; $display("FAIL pend_apply: flush %b pc %h want 1 1234", bus.flush, bus.pc_next);
    end
    tick();
    idle_inputs();
    bus.pc_cur = 16'h1234;
    #1;
    checks++;
    if ({bus.pend_valid, bus.halted, bus.pc_next} !== {2'b00, 16'h1236}) begin
      errors++; $display("FAIL pend_clear: pend %b halted %b pc %h want 0 0 1236", bus.pend_valid, bus.halted, bus.pc_next);
    end
  endtask

  task automatic test_halt();
    bus.pc_cur = 16'h0040; bus.stall = 1; bus.halt_dec = 1;
    tick();
    checks++;
    if (bus.halted !== 1'b0) begin
      errors++; $display("FAIL halt_under_stall: halted %b want 0", bus.halted);
    end
    bus.stall = 0;
    #1;
    checks++;
    if ({bus.flush, bus.pc_next} !== {1'b0, 16'h0040}) begin
      errors++; $display("FAIL halt_hold: flush %b pc %h want 0 0040", bus.flush, bus.pc_next);
    end
    tick();
    bus.halt_dec = 0;
    for (int i = 0; i < 10; i++) begin
      bus.br_valid = 1; bus.br_cond = 3'b111; bus.br_imm = 9'($urandom);
      bus.stall = 1'($urandom); bus.br_reg_valid = 1'($urandom);
      bus.br_reg_target = 16'($urandom);
      #1;
      checks++;
      if ({bus.halted, bus.pend_valid, bus.flush, bus.pc_next} !== {3'b100, 16'h0040}) begin
        errors++; $display("FAIL halt_stay[%0d]: halted %b pend %b flush %b pc %h want 1 0 0 0040", i, bus.halted, bus.pend_valid, bus.flush, bus.pc_next);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    logic [15:0] nxt;
    rst = 1;
    tick();
    rst = 0;
    bus.pc_cur = 16'h0200; bus.stall = 1;
    bus.br_reg_valid = 1; bus.br_reg_target = 16'h0ABC;
    tick();
    checks++;
    if (bus.pend_valid !== 1'b1) begin
      errors++; $display("FAIL mid_pend_set: pend %b want 1", bus.pend_valid);
    end
    rst = 1;
    #1;
    checks++;
    if (bus.pc_next !== 16'h0000) begin
      errors++; $display("FAIL mid_rst_pc: got %h want 0000", bus.pc_next);
    end
    tick();
    rst = 0;
    idle_inputs();
    bus.pc_cur = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({bus.pend_valid, bus.halted, bus.flush, bus.pc_next} !== {3'b000, 16'(2 * i + 2)}) begin
        errors++; $display("FAIL mid_resume[%0d]: pend %b halted %b flush %b pc %h want 0 0 0 %h", i, bus.pend_valid, bus.halted, bus.flush, bus.pc_next, 16'(2 * i + 2));
      end
      nxt = bus.pc_next;
      tick();
      bus.pc_cur = nxt;
    end
  endtask

  task automatic test_random();
    logic [16:0] exp_out;
    logic [15:0] exp_p2;
    rst = 1;
    tick();
    for (int i = 0; i < 600; i++) begin
      rst               = ($urandom_range(0, 29) == 0);
      bus.stall         = ($urandom_range(0, 3) == 0);
      bus.halt_dec      = ($urandom_range(0, 24) == 0);
      bus.br_valid      = 1'($urandom);
      bus.br_reg_valid  = ($urandom_range(0, 5) == 0);
      bus.br_cond       = 3'($urandom);
      bus.br_imm        = 9'($urandom);
      bus.br_reg_target = 16'($urandom);
      bus.flags         = 3'($urandom);
      bus.pc_cur        = 16'($urandom);
      #1;
      exp_out = m_out();
      exp_p2  = 16'((int'(bus.pc_cur) + 2) & 32'hFFFF);
      checks++;
      if ({bus.flush, bus.pc_next, bus.pc_plus2, bus.pend_valid, bus.halted} !==
          {exp_out, exp_p2, m_pend.size() != 0, m_halt}) begin
        errors++;
        $display("FAIL random[%0d]: flush/pc %h plus2 %h pend %b halted %b want %h %h %b %b",
                 i, {bus.flush, bus.pc_next}, bus.pc_plus2, bus.pend_valid, bus.halted,
                 exp_out, exp_p2, m_pend.size() != 0, m_halt);
      end
      tick();
    end
    rst = 0;
  endtask

  initial begin
    m_halt = 1'b0;
    test_reset();
    test_free_run();
    test_branch();
    test_wrap();
    test_pending();
    test_halt();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_next_ctrl.md
# pc_next_ctrl

Next-PC control stage sitting directly upstream of the 16-bit PC register: it reads the current PC and produces the value the register captures on every clock edge. The PC register has no write enable, so this block implements holding (stall, halt), sequential advance (PC+2), and branch redirection. It also implements the per-ISA condition check and a one-entry pending-redirect buffer for branches resolved during a stall.

## Interface
- No parameters: data width fixed at 16, branch immediate fixed at 9 bits.
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- pc_cur  input  16  current PC, from the PC register output
- stall  input  1  hazard stall; the PC must hold this cycle
- halt_dec  input  1  HLT instruction decoded at pc_cur
- br_valid  input  1  B (PC-relative) instruction resolved this cycle
- br_cond  input  3  condition code ccc of the branch
- br_imm  input  9  signed word offset of the branch
- br_reg_valid  input  1  BR (register-indirect) instruction resolved this cycle
- br_reg_target  input  16  absolute target for BR
- flags  input  3  {N, Z, V} from the flag register
- pc_next  output  16  value for the PC register's pc_in
- pc_plus2  output  16  pc_cur + 2, for the PCS instruction
- flush  output  1  a redirect is applied this cycle; fetch/decode must squash
- pend_valid  output  1  a redirect is held in the pending buffer
- halted  output  1  block is in HALT

## Operation
- FSM states are RUN, HALT. Reset puts the FSM in RUN. HALT is exited only by rst.
- Condition codes:
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 and N=0
  - 011 LT: N=1
  - 100 GTE: Z=1, or Z=0 and N=0
  - 101 LTE: N=1 or Z=1
  - 110 OV: V=1
  - 111 always
- taken = (br_valid and cond true) or br_reg_valid.
  - If both br_valid and br_reg_valid are asserted, br_reg_valid wins.
- Target calculation:
  - B target = pc_plus2 + (sign_extend(br_imm) << 1), computed mod 2^16, so wrap-around is allowed.
  - BR target = br_reg_target, used unmodified.
- pc_plus2 = pc_cur + 2 mod 2^16; 0xFFFE wraps to 0x0000.
- pc_next selection in RUN, highest priority first:
  1. rst: 0x0000.
  2. stall=1: pc_cur. If taken and pend_valid=0, latch the target and set pend_valid. If pend_valid is already 1, the new redirect is ignored (the first one wins).
  3. pend_valid=1 (not stalled): the pending target; clear pend_valid; flush=1.
  4. halt_dec=1: pc_cur; go to HALT next edge; any same-cycle branch is ignored.
  5. taken: the target; flush=1.
  6. otherwise: pc_plus2.
- In HALT: pc_next = pc_cur; all inputs are ignored; flush=0; pend_valid stays 0.
- halt_dec during stall is ignored; decode re-presents it.

## Timing
- Reset values: pc_next=0x0000 (combinational while rst=1), flush=0, pend_valid=0, halted=0. The PC register therefore reads 0x0000 on the edge after rst is sampled.
- pc_next, pc_plus2 and flush are combinational from the inputs and state, with zero-cycle latency. The PC register reflects them one edge later.
- pend_valid and the FSM state are registered and change on the rising edge following the triggering condition.
- halted rises on the edge after an unstalled halt_dec.
- rst asserted mid-stall with a pending redirect: the pending entry is discarded, pend_valid=0 the next cycle, and pc_next=0x0000 while rst is high.
- A pending redirect is applied on the first unstalled cycle, even if halt_dec or br_valid are also high that cycle; those are wrong-path and ignored.

## Test plan
- Reset then free run: pc_cur follows 0x0000, 0x0002, 0x0004 on consecutive edges; flush=0 throughout.
- B with taken condition: pc_cur=0x0010, br_valid=1, br_cond=001, Z=1, br_imm=0x1FC (-4) -> pc_next=0x000A, flush=1. Repeat with Z=0 -> pc_next=0x0012, flush=0.
- Wrap-around:
  - pc_cur=0xFFFE -> pc_plus2=0x0000.
  - pc_cur=0xFFF0, br_imm=0x0FF, cond=111 -> pc_next=0x01F0.
- Pending redirect: stall=1 for 3 cycles with br_reg_valid=1, target 0x1234, in the first stalled cycle -> pc_next=pc_cur and pend_valid=1 for the stall. In the first unstalled cycle, pc_next=0x1234, flush=1, then pend_valid=0. A second redirect to 0x5678 during the same stall is ignored.
- Halt: halt_dec=1 at pc_cur=0x0040 -> halted=1 next edge; the PC stays at 0x0040 for 10 cycles despite br_valid/cond=111. halt_dec under stall -> no halt.
- Reset mid-operation: while pend_valid=1, assert rst for 1 cycle -> pend_valid=0, halted=0, PC=0x0000, then normal PC+2 sequencing.
